byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
Downstream consumer of the 8-bit registered increment stage (DATA_O, synchronous to CLK_I). Packs qualified bytes little-endian into 32-bit words, buffers complete words in a small FIFO and presents them on a valid/ready interface to the bus side. Supports partial-word flush with byte enables and counts words dropped on FIFO overflow.

Parameters:
P_BYTES, 4, bytes per output word; legal values 2..4.
P_DEPTH, 4, output FIFO depth in words; power of two, minimum 2.
P_DELAY, 1, simulation delay on all register assignments.

Ports:
CLK_I  input  1  clock.
RST_X  input  1  asynchronous active-low reset.
DATA_I  input  8  byte from upstream stage; @sync CLK_I.
VALID_I  input  1  DATA_I qualifier; one byte accepted per cycle when high. No back-pressure upstream.
FLUSH_I  input  1  single-cycle pulse; emit the pending partial word.
WORD_O  output  8*P_BYTES  FIFO head word.
BEN_O  output  P_BYTES  byte enables of WORD_O; bit i covers WORD_O[8i+7:8i].
VALID_O  output  1  FIFO non-empty.
READY_I  input  1  consumer accepts WORD_O when VALID_O && READY_I.
DROP_O  output  1  one-cycle pulse when a word is discarded.
DROP_CNT_O  output  16  saturating count of discarded words.

Behaviour:
- Reset (async, RST_X low): lane counter 0, assembly register 0, FIFO empty; WORD_O=0, BEN_O=0, VALID_O=0, DROP_O=0, DROP_CNT_O=0. All state clears immediately on RST_X low, mid-word or mid-transfer; partial data is lost.
- Assembly: packer states EMPTY (count=0) and PARTIAL (count 1..P_BYTES-1). An accepted byte is written to lane[count], and count increments.
- Word complete: the byte that fills lane P_BYTES-1 produces a push of {assembled bytes, BEN=all ones} on the same clock edge; count returns to 0 (EMPTY).
- Flush: FLUSH_I in PARTIAL pushes the partial word with BEN low bits set for the filled lanes; unfilled lanes read 0; state becomes EMPTY. FLUSH_I in EMPTY is ignored.
- FLUSH_I together with VALID_I: the byte is included first, then the flush applies. If that byte completes the word, exactly one full word is pushed and nothing further.
- Latency: if the FIFO was empty, VALID_O rises in the cycle after the edge that accepted the completing byte, or after the edge that sampled FLUSH_I. WORD_O/BEN_O are registered first-word-fall-through outputs.
- FIFO: pop when VALID_O && READY_I. Push and pop in the same cycle are always permitted, including when the FIFO is full (the pop frees the slot). WORD_O/BEN_O hold stable while VALID_O && !READY_I.
- Overflow: a push while full without a simultaneous pop discards the new word; FIFO contents are unchanged. DROP_O pulses one cycle and DROP_CNT_O increments, saturating at 16'hFFFF.
- Empty: pop is impossible since VALID_O=0; READY_I is ignored.
- Pointers are log2(P_DEPTH)+1 bits and wrap naturally; full and empty are distinguished by the MSB.

Decomposition:
- Shared include header byte_pack_defs.vh: localparams for byte width (8), drop-counter width (16), counter saturation value.
- One sub-module, pack_word_fifo: parameterised width/depth FWFT FIFO with push/pop/full/empty. Assembly, flush and drop logic stay in byte_word_packer.

Test Plan:
- Reset then bytes 01,02,03,04 with VALID_I on consecutive cycles, READY_I=1 -> WORD_O=32'h04030201, BEN_O=4'hF, VALID_O high one cycle after 04 accepted, for one cycle.
- Bytes AA,BB then FLUSH_I, READY_I=1 -> WORD_O=32'h0000BBAA, BEN_O=4'h3; FLUSH_I pulsed again while EMPTY -> no word.
- Byte CC with FLUSH_I in the same cycle after 3 accepted bytes 11,22,33 -> a single word 32'hCC332211, BEN_O=4'hF, with no extra empty word.
- READY_I=0, 5 full words streamed (P_DEPTH=4) -> 4 words held and the 5th dropped; DROP_O pulses once, DROP_CNT_O=1. Then READY_I=1 -> the first 4 words emerge in order, unchanged.
- FIFO full, push and pop in the same cycle -> no drop; the word count stays at 4 and the new word appears last in order.
- RST_X asserted asynchronously mid-word with 2 words queued -> all outputs 0 immediately. After release, byte 55 with FLUSH_I -> WORD_O=32'h00000055, BEN_O=4'h1.

Source files
------------

// File: rtl/byte_word_packer_pkg.sv
// byte_word_packer_pkg
//   Shared constants and types for the byte-to-word packer.
//   BYTE_W       : width of one upstream byte lane
//   DROP_CNT_W   : width of the discarded-word counter
//   DROP_CNT_MAX : saturation value of the discarded-word counter
//   pack_state_e : assembly state (EMPTY / PARTIAL)
package byte_word_packer_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    PK_EMPTY   = 1'b0,
    PK_PARTIAL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/pack_word_fifo.sv
// pack_word_fifo
//   First-word-fall-through FIFO built from registers. The head entry is
//   presented on data_o whenever the FIFO is non-empty; data_o reads 0 when
//   empty. A push while full is accepted only if a pop happens in the same
//   cycle (the pop frees the slot).
//   Ports:
//     CLK_I, RST_X : clock, asynchronous active-low reset
//     push_i       : write data_i (ignored when full without a pop)
//     pop_i        : remove head entry (ignored when empty)
//     data_i       : write data
//     data_o       : head entry
//     full_o       : all P_DEPTH entries occupied
//     empty_o      : no entries
module pack_word_fifo #(
  parameter int unsigned P_WIDTH = 36,
  parameter int unsigned P_DEPTH = 4
) (
  input  logic               CLK_I,
  input  logic               RST_X,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [P_WIDTH-1:0] data_i,
  output logic [P_WIDTH-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned AW = $clog2(P_DEPTH);

  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [AW:0]        wptr_q, wptr_d;
  logic [AW:0]        rptr_q, rptr_d;
  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [P_WIDTH-1:0] mem_d [P_DEPTH];
  logic               do_push;
  logic               do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = data_i;
      wptr_d                = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Packs qualified bytes little-endian into P_BYTES-byte words, queues
//   finished words in a FWFT FIFO and presents them on a valid/ready port.
//   A flush emits a pending partial word with byte enables for the filled
//   lanes. Words pushed into a full FIFO (with no same-cycle pop) are
//   discarded and counted.
//   Ports:
//     CLK_I, RST_X : clock, asynchronous active-low reset
//     DATA_I       : upstream byte, qualified by VALID_I
//     FLUSH_I      : pulse, emit pending partial word
//     WORD_O       : FIFO head word (0 when empty)
//     BEN_O        : byte enables of WORD_O
//     VALID_O      : FIFO non-empty
//     READY_I      : consumer accepts WORD_O when VALID_O is high
//     DROP_O       : one-cycle pulse per discarded word
//     DROP_CNT_O   : saturating count of discarded words
//   P_DELAY is kept for compatibility with the simulation-delay flavour of
//   this block; the synthesizable registers carry no delay.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   PK_EMPTY   | no bytes pending, lane counter 0
//   PK_PARTIAL | 1..P_BYTES-1 bytes pending in the assembly reg
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int unsigned P_BYTES = 4,
  parameter int unsigned P_DEPTH = 4,
  parameter int unsigned P_DELAY = 1
) (
  input  logic                      CLK_I,
  input  logic                      RST_X,
  input  logic [BYTE_W-1:0]         DATA_I,
  input  logic                      VALID_I,
  input  logic                      FLUSH_I,
  output logic [BYTE_W*P_BYTES-1:0] WORD_O,
  output logic [P_BYTES-1:0]        BEN_O,
  output logic                      VALID_O,
  input  logic                      READY_I,
  output logic                      DROP_O,
  output logic [DROP_CNT_W-1:0]     DROP_CNT_O
);

  localparam int unsigned WORD_W = BYTE_W * P_BYTES;
  localparam int unsigned FIFO_W = WORD_W + P_BYTES;
  localparam logic [1:0]  LAST_LANE = 2'(P_BYTES - 1);

  pack_state_e                     state_q, state_d;
  logic [1:0]                      count_q, count_d;
  logic [P_BYTES-1:0][BYTE_W-1:0]  lanes_q, lanes_d;
  logic                            drop_q, drop_d;
  logic [DROP_CNT_W-1:0]           drop_cnt_q, drop_cnt_d;

  logic [P_BYTES-1:0][BYTE_W-1:0]  lanes_new;
  logic [2:0]                      fill;
  logic                            complete;
  logic                            push;
  logic [P_BYTES-1:0]              push_ben;
  logic [WORD_W-1:0]               push_word;
  logic                            drop;
  logic                            fifo_push;
  logic                            fifo_pop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [FIFO_W-1:0]               fifo_head;

  always_comb begin
    lanes_new = lanes_q;
    for (int i = 0; i < P_BYTES; i++) begin
      if (VALID_I && (count_q == 2'(i))) lanes_new[i] = DATA_I;
    end
    // Lanes occupied once this cycle's byte (if any) is included.
    fill     = {1'b0, count_q} + {2'b00, VALID_I};
    complete = VALID_I && (count_q == LAST_LANE);

    push     = 1'b0;
    push_ben = '0;
    if (complete) begin
      push     = 1'b1;
      push_ben = '1;
    end else if (FLUSH_I && (state_q == PK_PARTIAL || VALID_I)) begin
      push = 1'b1;
      for (int i = 0; i < P_BYTES; i++) begin
        push_ben[i] = (3'(i) < fill);
      end
    end

    push_word = '0;
    for (int i = 0; i < P_BYTES; i++) begin
      push_word[i*BYTE_W +: BYTE_W] = push_ben[i] ? lanes_new[i] : '0;
    end

    if (push) begin
      state_d = PK_EMPTY;
      count_d = '0;
      lanes_d = '0;
    end else begin
      state_d = (fill != 3'd0) ? PK_PARTIAL : PK_EMPTY;
      count_d = fill[1:0];
      lanes_d = lanes_new;
    end

    fifo_pop  = !fifo_empty && READY_I;
    drop      = push && fifo_full && !fifo_pop;
    fifo_push = push && !drop;

    drop_d     = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != DROP_CNT_MAX)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= PK_EMPTY;
      count_q    <= '0;
      lanes_q    <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lanes_q    <= lanes_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  pack_word_fifo #(
    .P_WIDTH (FIFO_W),
    .P_DEPTH (P_DEPTH)
  ) u_fifo (
    .CLK_I   (CLK_I),
    .RST_X   (RST_X),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({push_ben, push_word}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign WORD_O     = fifo_head[WORD_W-1:0];
  assign BEN_O      = fifo_head[FIFO_W-1:WORD_W];
  assign VALID_O    = !fifo_empty;
  assign DROP_O     = drop_q;
  assign DROP_CNT_O = drop_cnt_q;

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

  logic        CLK_I = 1'b0;
  logic        RST_X = 1'b0;
  logic [7:0]  DATA_I = 8'h00;
  logic        VALID_I = 1'b0;
  logic        FLUSH_I = 1'b0;
  logic [31:0] WORD_O;
  logic [3:0]  BEN_O;
  logic        VALID_O;
  logic        READY_I = 1'b0;
  logic        DROP_O;
  logic [15:0] DROP_CNT_O;

  int n_vec = 0;
  int n_err = 0;

  byte_word_packer #(.P_BYTES(4), .P_DEPTH(4), .P_DELAY(1)) dut (
    .CLK_I      (CLK_I),
    .RST_X      (RST_X),
    .DATA_I     (DATA_I),
    .VALID_I    (VALID_I),
    .FLUSH_I    (FLUSH_I),
    .WORD_O     (WORD_O),
    .BEN_O      (BEN_O),
    .VALID_O    (VALID_O),
    .READY_I    (READY_I),
    .DROP_O     (DROP_O),
    .DROP_CNT_O (DROP_CNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    DATA_I  = b;
    VALID_I = 1'b1;
    FLUSH_I = fl;
    tick();
    VALID_I = 1'b0;
    FLUSH_I = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] base);
    for (int i = 0; i < 4; i++) send_byte(base + 8'(i), 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", VALID_O, 1'b0);
    check("rst_word", WORD_O, 32'h0);
    check("rst_ben", BEN_O, 4'h0);
    check("rst_drop", DROP_O, 1'b0);
    check("rst_dcnt", DROP_CNT_O, 16'h0);
    RST_X   = 1'b1;
    READY_I = 1'b1;
    tick();

    // Full word, one-cycle visibility with READY_I high
    send_byte(8'h01, 1'b0);
    check("w1_early_valid", VALID_O, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    check("w1_valid", VALID_O, 1'b1);
    check("w1_word", WORD_O, 32'h04030201);
    check("w1_ben", BEN_O, 4'hF);
    tick();
    check("w1_gone", VALID_O, 1'b0);

    // Partial flush, then flush while empty
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    FLUSH_I = 1'b1;
    tick();
    FLUSH_I = 1'b0;
    check("fl_valid", VALID_O, 1'b1);
    check("fl_word", WORD_O, 32'h0000BBAA);
    check("fl_ben", BEN_O, 4'h3);
    tick();
    check("fl_gone", VALID_O, 1'b0);
    FLUSH_I = 1'b1;
    tick();
    FLUSH_I = 1'b0;
    check("fl_empty_ign", VALID_O, 1'b0);
    tick();
    check("fl_empty_ign2", VALID_O, 1'b0);

    // Completing byte together with flush
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'hCC, 1'b1);
    check("cf_valid", VALID_O, 1'b1);
    check("cf_word", WORD_O, 32'hCC332211);
    check("cf_ben", BEN_O, 4'hF);
    tick();
    check("cf_no_extra", VALID_O, 1'b0);
    tick();
    check("cf_no_extra2", VALID_O, 1'b0);

    // Overflow: 5 words into a 4-deep FIFO with READY_I low
    READY_I = 1'b0;
    send_word(8'h10);
    check("ov_first_valid", VALID_O, 1'b1);
    check("ov_first_word", WORD_O, 32'h13121110);
    send_word(8'h20);
    send_word(8'h30);
    send_word(8'h40);
    check("ov_hold_word", WORD_O, 32'h13121110);
    check("ov_no_drop_yet", DROP_O, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    send_byte(8'h53, 1'b0);
    check("ov_drop_pulse", DROP_O, 1'b1);
    check("ov_dcnt", DROP_CNT_O, 16'h1);
    tick();
    check("ov_drop_end", DROP_O, 1'b0);
    check("ov_dcnt_hold", DROP_CNT_O, 16'h1);
    check("ov_head_kept", WORD_O, 32'h13121110);
    READY_I = 1'b1;
    tick();
    check("ov_rd2", WORD_O, 32'h23222120);
    tick();
    check("ov_rd3", WORD_O, 32'h33323130);
    tick();
    check("ov_rd4", WORD_O, 32'h43424140);
    check("ov_rd4_ben", BEN_O, 4'hF);
    tick();
    check("ov_drained", VALID_O, 1'b0);

    // Full FIFO with simultaneous push and pop
    READY_I = 1'b0;
    send_word(8'h60);
    send_word(8'h70);
    send_word(8'h80);
    send_word(8'h90);
    send_byte(8'hA0, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    READY_I = 1'b1;
    send_byte(8'hA3, 1'b0);
    READY_I = 1'b0;
    check("pp_no_drop", DROP_O, 1'b0);
    check("pp_head", WORD_O, 32'h73727170);
    tick();
    check("pp_dcnt", DROP_CNT_O, 16'h1);
    READY_I = 1'b1;
    tick();
    check("pp_rd2", WORD_O, 32'h83828180);
    tick();
    check("pp_rd3", WORD_O, 32'h93929190);
    tick();
    check("pp_rd4", WORD_O, 32'hA3A2A1A0);
    tick();
    check("pp_drained", VALID_O, 1'b0);

    // Asynchronous reset mid-word with 2 words queued
    READY_I = 1'b0;
    send_word(8'hB0);
    send_word(8'hC0);
    send_byte(8'hD0, 1'b0);
    send_byte(8'hD1, 1'b0);
    check("ar_pre_valid", VALID_O, 1'b1);
    #2;
    RST_X = 1'b0;
    #1;
    check("ar_valid", VALID_O, 1'b0);
    check("ar_word", WORD_O, 32'h0);
    check("ar_ben", BEN_O, 4'h0);
    check("ar_dcnt", DROP_CNT_O, 16'h0);
    @(negedge CLK_I);
    RST_X   = 1'b1;
    READY_I = 1'b1;
    tick();
    check("ar_post_valid", VALID_O, 1'b0);
    send_byte(8'h55, 1'b1);
    check("ar_55_valid", VALID_O, 1'b1);
    check("ar_55_word", WORD_O, 32'h00000055);
    check("ar_55_ben", BEN_O, 4'h1);
    tick();
    check("ar_55_gone", VALID_O, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
